// File: rtl/fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_controller_pkg;

  typedef enum logic [1:0] {
    RUN,
    FULL,
    HALT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [1:0]  FETCH_DEPTH = 2'd2;
  localparam logic [31:0] PC_STEP     = 32'd4;

  function automatic logic misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, instr}; head entry is held in its own register.
module fetch_buffer
  import fetch_controller_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         enq,
  input  logic         deq,
  input  logic         flush,
  input  fetch_entry_t wr_entry,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t tail;

  // Head is always slot 0 so the decode-facing outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({enq, deq})
        2'b10: begin
          if (count == 2'd0) head <= wr_entry;
          else               tail <= wr_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= wr_entry;
          end else begin
            head <= tail;
            tail <= wr_entry;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch controller: pc register, run/full/halt FSM and a 2-entry fetch buffer.
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        fetch_valid,
  output logic [31:0] fetch_instr,
  output logic [31:0] fetch_pc,
  input  logic        fetch_ready,
  output logic        misalign_err
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [1:0]   count;
  logic [1:0]   count_next;
  logic         redir_ok;
  logic         redir_bad;
  logic         flush;
  logic         deq;
  logic         enq;
  fetch_entry_t wr_entry;
  fetch_entry_t head;

  assign imem_addr   = pc;
  assign fetch_valid = (count != 2'd0);
  assign fetch_instr = head.instr;
  assign fetch_pc    = head.pc;

  // Once the error is latched, redirects are ignored until reset.
  always_comb begin
    redir_ok   = redirect_valid && !misalign_err && !misaligned(redirect_pc);
    redir_bad  = redirect_valid && !misalign_err &&  misaligned(redirect_pc);
    flush      = redir_ok || redir_bad;
    deq        = fetch_valid && fetch_ready;
    enq        = (state == RUN) && !flush && !halt && ((count != FETCH_DEPTH) || deq);
    count_next = count + {1'b0, enq} - {1'b0, deq};
    wr_entry   = '{pc: pc, instr: imem_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc           <= RESET_PC;
      state        <= RUN;
      misalign_err <= 1'b0;
    end else if (redir_bad) begin
      misalign_err <= 1'b1;
      state        <= HALT;
    end else if (redir_ok) begin
      pc    <= redirect_pc;
      state <= halt ? HALT : RUN;
    end else begin
      case (state)
        RUN: begin
          if (halt) begin
            state <= HALT;
          end else begin
            if (enq) pc <= pc + PC_STEP;
            if ((count_next == FETCH_DEPTH) && !deq) state <= FULL;
          end
        end
        FULL: begin
          if (halt)     state <= HALT;
          else if (deq) state <= RUN;
        end
        HALT: begin
          if (!halt && !misalign_err) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

  fetch_buffer u_buf (
    .clk      (clk),
    .reset    (reset),
    .enq      (enq),
    .deq      (deq),
    .flush    (flush),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count)
  );

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller against a queue-based reference model.
module tb_fetch_controller;
  import fetch_controller_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready = 1'b0;
  logic        misalign_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  fetch_entry_t mq[$];
  logic [31:0]  m_pc;
  bit           m_err;
  bit           m_halt;
  bit           m_full;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  assign imem_data = memf(imem_addr);

  fetch_controller #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc   = 32'h0000_0000;
    m_err  = 1'b0;
    m_halt = 1'b0;
    m_full = 1'b0;
  endtask

  // One clock of the fetch rules, evaluated on the inputs present before the edge.
  task automatic model_step();
    bit          deq;
    int unsigned n0;
    bit          can_fetch;
    deq = (mq.size() != 0) && fetch_ready;
    n0  = mq.size();
    if (!m_err && redirect_valid) begin
      mq.delete();
      m_full = 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        m_err  = 1'b1;
        m_halt = 1'b1;
      end else begin
        m_pc   = redirect_pc;
        m_halt = halt;
      end
    end else begin
      can_fetch = !m_halt && !m_full && !halt && (n0 < 2 || deq);
      if (deq) void'(mq.pop_front());
      if (can_fetch) begin
        mq.push_back('{pc: m_pc, instr: memf(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      if (m_halt) begin
        m_halt = halt || m_err;
      end else if (halt) begin
        m_halt = 1'b1;
        m_full = 1'b0;
      end else if (m_full) begin
        m_full = !deq;
      end else begin
        m_full = (mq.size() == 2) && !deq;
      end
    end
  endtask

  task automatic compare_model();
    check("valid", 32'(fetch_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("head_pc", fetch_pc, mq[0].pc);
      check("head_instr", fetch_instr, mq[0].instr);
    end
    check("imem_addr", imem_addr, m_pc);
    check("err", 32'(misalign_err), 32'(m_err));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    halt = 1'b0;
    model_reset();
    #1;
    check("rst_valid", 32'(fetch_valid), 32'd0);
    check("rst_pc", fetch_pc, 32'd0);
    check("rst_instr", fetch_instr, 32'd0);
    check("rst_err", 32'(misalign_err), 32'd0);
    check("rst_addr", imem_addr, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    do_reset();

    // Streaming from reset with decode always ready
    fetch_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("seq_pc", fetch_pc, 32'(i * 4));
      check("seq_instr", fetch_instr, memf(32'(i * 4)));
    end

    // Backpressure fills the buffer, then drains without gaps
    do_reset();
    fetch_ready = 1'b0;
    repeat (5) cyc();
    check("full_count", 32'(dut.u_buf.count), 32'd2);
    check("full_state", 32'(dut.state), 32'(FULL));
    check("full_addr", imem_addr, 32'h8);
    fetch_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("drain_valid", 32'(fetch_valid), 32'd1);
      check("drain_pc", fetch_pc, 32'(i * 4));
      cyc();
    end

    // Aligned redirect while full
    fetch_ready = 1'b0;
    repeat (2) cyc();
    fetch_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    cyc();
    redirect_valid = 1'b0;
    check("redir_bubble", 32'(fetch_valid), 32'd0);
    cyc();
    check("redir_pc0", fetch_pc, 32'h40);
    cyc();
    check("redir_pc1", fetch_pc, 32'h44);

    // Misaligned redirect latches the error and halts until reset
    fetch_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    cyc();
    redirect_valid = 1'b0;
    check("mis_err", 32'(misalign_err), 32'd1);
    check("mis_state", 32'(dut.state), 32'(HALT));
    check("mis_valid", 32'(fetch_valid), 32'd0);
    fetch_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      halt = i[0];
      cyc();
    end
    halt = 1'b0;
    cyc();
    check("mis_stuck_valid", 32'(fetch_valid), 32'd0);
    check("mis_stuck_addr", imem_addr, 32'h48);
    do_reset();

    // Wrap-around at the top of the address space
    fetch_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    cyc();
    redirect_valid = 1'b0;
    check("wrap_bubble", 32'(fetch_valid), 32'd0);
    cyc();
    check("wrap_pc0", fetch_pc, 32'hFFFF_FFF8);
    cyc();
    check("wrap_pc1", fetch_pc, 32'hFFFF_FFFC);
    cyc();
    check("wrap_pc2", fetch_pc, 32'h0000_0000);

    // Halt drains the buffer with the pc frozen, then resumes from it
    halt = 1'b1;
    repeat (3) cyc();
    check("halt_valid", 32'(fetch_valid), 32'd0);
    check("halt_addr", imem_addr, 32'h4);
    halt = 1'b0;
    repeat (2) cyc();
    check("resume_valid", 32'(fetch_valid), 32'd1);
    check("resume_pc", fetch_pc, 32'h4);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      fetch_ready = ($urandom_range(0, 3) != 0);
      halt = ($urandom_range(0, 9) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      r = $urandom;
      redirect_pc = r & 32'h0000_00FC;
      if ($urandom_range(0, 7) == 0) redirect_pc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) redirect_pc[31:8] = '1;
      cyc();
      if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 149) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
